seg7_scan: RTL and testbench

//  Time-multiplexed driver for the 4-digit common-anode seven-segment display on the Cu IO board.

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/seg7_decode.sv | 17 +
 rtl/seg7_scan.sv | 120 ++++++++++++
 tb/tb_seg7_scan.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment table for the 4-digit display driver.
// Segment constants are active-high in .gfedcba order.
package seg7_pkg;

  localparam int DIGITS = 4;

  localparam logic [7:0] SEG_0   = 8'h3F;
  localparam logic [7:0] SEG_1   = 8'h06;
  localparam logic [7:0] SEG_2   = 8'h5B;
  localparam logic [7:0] SEG_3   = 8'h4F;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'h6D;
  localparam logic [7:0] SEG_6   = 8'h7D;
  localparam logic [7:0] SEG_7   = 8'h07;
  localparam logic [7:0] SEG_8   = 8'h7F;
  localparam logic [7:0] SEG_9   = 8'h6F;
  localparam logic [7:0] SEG_A   = 8'h77;
  localparam logic [7:0] SEG_B   = 8'h7C;
  localparam logic [7:0] SEG_C   = 8'h39;
  localparam logic [7:0] SEG_D   = 8'h5E;
  localparam logic [7:0] SEG_E   = 8'h79;
  localparam logic [7:0] SEG_F   = 8'h71;
  localparam logic [7:0] SEG_DOT = 8'h80;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    s = SEG_0;
    unique case (n)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point -> active-low .gfedcba pattern.
// Ports: i_nib hex digit, i_dp point lit, i_blank force dark, o_seg active-low segments.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = ~(hex7(i_nib) | (i_dp ? SEG_DOT : 8'h00));
    if (i_blank) o_seg = 8'hFF;
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit common-anode driver with double-buffered load, PWM, lz blanking.
// Ports: clk/rst_n, in_* valid/ready load port, bright duty, frame_start pulse, io_sel/io_seg active-low.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 65536,
  parameter int GUARD    = 64
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_value,
  input  logic [DIGITS-1:0] in_dp,
  input  logic              in_lzb,
  input  logic [3:0]        bright,
  output logic              frame_start,
  output logic [3:0]        io_sel,
  output logic [7:0]        io_seg
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_idx;
  logic [15:0]       r_act_val;
  logic [DIGITS-1:0] r_act_dp;
  logic              r_act_lzb;
  logic [15:0]       r_pnd_val;
  logic [DIGITS-1:0] r_pnd_dp;
  logic              r_pnd_lzb;
  logic              r_pnd_full;

  logic       w_wrap;
  logic       w_bound;
  logic       w_xfer;
  logic       w_dark;
  logic       w_lead0;
  logic [3:0] w_nib;
  logic [7:0] w_seg;

  assign in_ready = ~r_pnd_full;
  assign w_wrap   = r_cnt == CW'(SCAN_DIV - 1);
  assign w_bound  = w_wrap && (r_idx == 2'd0);
  assign w_xfer   = in_valid && ~r_pnd_full;

  // Top 4 counter bits act as the PWM phase within a slot.
  assign w_dark = (r_cnt < CW'(GUARD)) ||
                  (r_cnt[CW-1 -: 4] >= bright);

  assign w_nib = r_act_val[{r_idx, 2'b00} +: 4];

  // Digit idx is leading when it and every digit to its left are zero.
  always_comb begin
    w_lead0 = 1'b0;
    unique case (r_idx)
      2'd3: w_lead0 = r_act_val[15:12] == 4'h0;
      2'd2: w_lead0 = r_act_val[15:8] == 8'h00;
      2'd1: w_lead0 = r_act_val[15:4] == 12'h000;
      2'd0: w_lead0 = 1'b0;
    endcase
  end

  seg7_decode u_dec (
    .i_nib   (w_nib),
    .i_dp    (r_act_dp[r_idx]),
    .i_blank (r_act_lzb && w_lead0),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd3;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_wrap) r_idx <= r_idx - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_val  <= '0;
      r_act_dp   <= '0;
      r_act_lzb  <= 1'b0;
      r_pnd_val  <= '0;
      r_pnd_dp   <= '0;
      r_pnd_lzb  <= 1'b0;
      r_pnd_full <= 1'b0;
    end else if (w_bound && r_pnd_full) begin
      r_act_val  <= r_pnd_val;
      r_act_dp   <= r_pnd_dp;
      r_act_lzb  <= r_pnd_lzb;
      r_pnd_full <= 1'b0;
    end else if (w_xfer) begin
      r_pnd_val  <= in_value;
      r_pnd_dp   <= in_dp;
      r_pnd_lzb  <= in_lzb;
      r_pnd_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_sel      <= 4'hF;
      io_seg      <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_bound;
      if (w_dark) begin
        io_sel <= 4'hF;
        io_seg <= 8'hFF;
      end else begin
        io_sel <= ~(4'b0001 << r_idx);
        io_seg <= w_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: frame-position reference model feeds a queue,
// a monitor pops and compares each cycle.
module tb_seg7_scan;

  localparam int SD    = 16;
  localparam int G     = 2;
  localparam int FRAME = 4 * SD;

  localparam logic [6:0] SEGTAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lzb;
  } word_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fs;
    logic       rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = '0;
  logic [3:0]  in_dp = '0;
  logic        in_lzb = 1'b0;
  logic [3:0]  bright = 4'd15;
  logic        frame_start;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;

  int total = 0;
  int bad = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;

  exp_t sb[$];

  seg7_scan #(.SCAN_DIV(SD), .GUARD(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .in_dp       (in_dp),
    .in_lzb      (in_lzb),
    .bright      (bright),
    .frame_start (frame_start),
    .io_sel      (io_sel),
    .io_seg      (io_seg)
  );

  always #5 clk = ~clk;

  // Expected display for slot position (c within slot, digit d) of word w.
  function automatic exp_t model_out(word_t w, int c, int d, int br);
    exp_t e;
    e.sel = 4'hF;
    e.seg = 8'hFF;
    e.fs  = 1'b0;
    e.rdy = 1'b0;
    if (c >= G && (c * 16) / SD < br) begin
      e.sel = ~(4'b0001 << d);
      if (w.lzb && d > 0 && (w.value >> (4 * d)) == 16'h0)
        e.seg = 8'hFF;
      else
        e.seg = ~{w.dp[d], SEGTAB[w.value[4*d +: 4]]};
    end
    return e;
  endfunction

  // Reference: frame position counts edges since reset; word moves
  // pending->active only on the last cycle of a frame.
  int    p;
  word_t act;
  word_t pnd;
  bit    pnd_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p = 0;
      act = '{16'h0, 4'h0, 1'b0};
      pnd_full = 0;
      sb.delete();
    end else begin
      exp_t e;
      e = model_out(act, p % SD, 3 - p / SD, int'(bright));
      e.fs = (p == FRAME - 1);
      if (p == FRAME - 1 && pnd_full) begin
        act = pnd;
        pnd_full = 0;
      end else if (in_valid && !pnd_full) begin
        pnd = '{in_value, in_dp, in_lzb};
        pnd_full = 1;
      end
      e.rdy = !pnd_full;
      sb.push_back(e);
      p = (p + 1) % FRAME;
    end
  end

  task automatic chk(string nm, logic [7:0] a, logic [7:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, a, x);
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      chk("rst_sel", {4'h0, io_sel}, 8'h0F);
      chk("rst_seg", io_seg, 8'hFF);
      chk("rst_rdy", {7'h0, in_ready}, 8'h01);
      chk("rst_fs", {7'h0, frame_start}, 8'h00);
    end else begin
      if (tmo_cnt != tmo_seen) begin
        total++;
        bad++;
        $display("FAIL timeout t=%0t got=%0d want=%0d", $time, tmo_cnt, tmo_seen);
        tmo_seen = tmo_cnt;
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sel", {4'h0, io_sel}, {4'h0, e.sel});
        chk("seg", io_seg, e.seg);
        chk("fs", {7'h0, frame_start}, {7'h0, e.fs});
        chk("rdy", {7'h0, in_ready}, {7'h0, e.rdy});
      end
    end
  end

  task automatic send(logic [15:0] v, logic [3:0] d, logic z);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    in_dp    = d;
    in_lzb   = z;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) tmo_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    in_value = 16'($urandom);
    in_dp    = 4'($urandom);
    in_lzb   = 1'($urandom);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) tmo_cnt++;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(FRAME + 8);

    idle(20);
    send(16'hDEAD, 4'b0001, 1'b0);
    idle(2 * FRAME);

    send(16'h1234, 4'b0000, 1'b0);
    send(16'hBEEF, 4'b0000, 1'b0);
    idle(3 * FRAME);

    send(16'h0042, 4'b0000, 1'b1);
    idle(2 * FRAME);
    send(16'h0000, 4'b1111, 1'b1);
    idle(2 * FRAME);

    bright = 4'd0;
    idle(FRAME + 4);
    bright = 4'd8;
    idle(FRAME + 4);
    bright = 4'd15;

    // Transfer landing exactly on the frame-boundary cycle.
    wait_fs();
    idle(62);
    send(16'hA5C3, 4'b1010, 1'b0);
    idle(2 * FRAME);

    // Reset mid-slot with a word still pending.
    send(16'h7777, 4'b0000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(FRAME + 4);

    for (int i = 0; i < 30; i++) begin
      bright = 4'($urandom_range(0, 15));
      if (i % 3 == 0) bright = 4'd15;
      send(16'($urandom) & masks[$urandom_range(0, 4)],
           4'($urandom), 1'($urandom));
      idle($urandom_range(0, 90));
      if (i % 5 == 0) bright = 4'($urandom_range(0, 15));
      idle($urandom_range(0, 40));
    end

    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
